// File: rtl/psram_req_arbiter.sv
// ---------------------------------------------------------------------------
// psram_req_arbiter
//
// Shares one byte-wide PSRAM controller between two clients, A and B.
// Each client holds a request level until it sees its DONE pulse. The arbiter
// keeps only one transaction in flight. For each transaction it registers the
// command fields, strobes the controller once, and waits for a full
// busy-high / busy-low handshake. It then returns completion, and read data
// for reads, to the client that was granted.
//
// Configuration macro:
//   PSRAM_ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate
//                                          between clients (pointer updates
//                                          only on a grant)
//                             undefined -> client A always wins (fixed
//                                          priority, no pointer register)
//
// Parameters:
//   ADDR_WIDTH           byte-address width of both clients and controller
//
// Ports:
//   i_CLK                sole clock, rising edge
//   i_RST_n              synchronous active-low reset
//   i_A_REQ / i_B_REQ    request level, held until the matching DONE
//   i_A_WR / i_B_WR      1 = write8, 0 = read8 (stable while REQ is high)
//   i_A_ADDR / i_B_ADDR  byte address (stable while REQ is high)
//   i_A_WDATA/i_B_WDATA  write byte (stable while REQ is high)
//   o_A_DONE / o_B_DONE  one-cycle completion pulse
//   o_A_RDATA/o_B_RDATA  read byte; valid with DONE, held until the next read
//   o_PSRAM_READ8        one-cycle read command strobe
//   o_PSRAM_WRITE8       one-cycle write command strobe
//   o_PSRAM_ADDRESS      registered command address
//   o_PSRAM_WRITE_DATA   registered command write byte
//   i_PSRAM_BUSY         controller busy, including its power-up init phase
//   i_PSRAM_READ_DATA    controller read byte, valid while BUSY is low
// ---------------------------------------------------------------------------
module psram_req_arbiter #(
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_n,

  input  logic                  i_A_REQ,
  input  logic                  i_A_WR,
  input  logic [ADDR_WIDTH-1:0] i_A_ADDR,
  input  logic [7:0]            i_A_WDATA,
  output logic                  o_A_DONE,
  output logic [7:0]            o_A_RDATA,

  input  logic                  i_B_REQ,
  input  logic                  i_B_WR,
  input  logic [ADDR_WIDTH-1:0] i_B_ADDR,
  input  logic [7:0]            i_B_WDATA,
  output logic                  o_B_DONE,
  output logic [7:0]            o_B_RDATA,

  output logic                  o_PSRAM_READ8,
  output logic                  o_PSRAM_WRITE8,
  output logic [ADDR_WIDTH-1:0] o_PSRAM_ADDRESS,
  output logic [7:0]            o_PSRAM_WRITE_DATA,
  input  logic                  i_PSRAM_BUSY,
  input  logic [7:0]            i_PSRAM_READ_DATA
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic any_req;
  logic grant;
  logic grant_b;
  logic complete;
  logic done_cycle;
  logic op_b;
  logic op_wr;

  assign any_req = i_A_REQ | i_B_REQ;

  // A DONE pulse is only ever high in the first IDLE cycle after a
  // transaction. The client cannot drop its REQ until it has seen that
  // pulse, so a grant in that cycle would repeat the finished request.
  assign done_cycle = o_A_DONE | o_B_DONE;

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
  logic prio_b;

  // On a tie, the client that was not granted last wins. After reset the
  // pointer favours A.
  assign grant_b = i_B_REQ & (~i_A_REQ | prio_b);

  // The pointer moves only when a grant is actually made, so it hands
  // priority to the other client.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      prio_b <= 1'b0;
    end else if (grant) begin
      prio_b <= ~grant_b;
    end
  end
`else
  // Fixed priority: B is chosen only when A is not asking.
  assign grant_b = i_B_REQ & ~i_A_REQ;
`endif

  // State register.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the grant/complete qualifiers for the datapath.
  // The busy value seen during ISSUE is ignored: the controller has not yet
  // seen the strobe. So WAIT_BUSY must see busy rise before WAIT_DONE can
  // take a low busy as completion.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (!i_PSRAM_BUSY && any_req && !done_cycle) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_PSRAM_BUSY) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!i_PSRAM_BUSY) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command strobes come straight from the state register. They are high
  // only in ISSUE, which lasts one cycle, so each grant gives one strobe.
  assign o_PSRAM_READ8  = (state == ISSUE) & ~op_wr;
  assign o_PSRAM_WRITE8 = (state == ISSUE) &  op_wr;

  // Datapath. On a grant, capture the chosen client's command; the fields
  // then hold until the next grant. On completion, pulse the owner's DONE
  // and, for a read, load the controller byte into the owner's RDATA.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      op_b               <= 1'b0;
      op_wr              <= 1'b0;
      o_PSRAM_ADDRESS    <= '0;
      o_PSRAM_WRITE_DATA <= '0;
      o_A_DONE           <= 1'b0;
      o_B_DONE           <= 1'b0;
      o_A_RDATA          <= '0;
      o_B_RDATA          <= '0;
    end else begin
      o_A_DONE <= complete & ~op_b;
      o_B_DONE <= complete &  op_b;

      if (grant) begin
        op_b               <= grant_b;
        op_wr              <= grant_b ? i_B_WR    : i_A_WR;
        o_PSRAM_ADDRESS    <= grant_b ? i_B_ADDR  : i_A_ADDR;
        o_PSRAM_WRITE_DATA <= grant_b ? i_B_WDATA : i_A_WDATA;
      end

      if (complete && !op_wr) begin
        if (op_b) begin
          o_B_RDATA <= i_PSRAM_READ_DATA;
        end else begin
          o_A_RDATA <= i_PSRAM_READ_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_psram_req_arbiter
//
// Bench for psram_req_arbiter. Three processes surround the DUT:
//   - a PSRAM controller model that raises busy after each strobe, serves
//     reads from a sparse memory, and can hold an init busy period;
//   - a transaction-level reference that predicts every DUT output;
//   - a compare process that checks the DUT against the reference once per
//     cycle.
// Directed scenarios add hand-computed literal checks on top.
// Follows PSRAM_ARB_ROUND_ROBIN_EN the same way the DUT does.
// ---------------------------------------------------------------------------
module tb_psram_req_arbiter;

  localparam int AW       = 22;
  localparam int BUSY_LEN = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_wdata, b_wdata;
  logic          a_done, b_done;
  logic [7:0]    a_rdata, b_rdata;
  logic          rd8, wr8;
  logic [AW-1:0] p_addr;
  logic [7:0]    p_wdata;
  logic          busy = 1'b0;
  logic [7:0]    rd_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  psram_req_arbiter #(.ADDR_WIDTH(AW)) dut (
    .i_CLK(clk), .i_RST_n(rst_n),
    .i_A_REQ(a_req), .i_A_WR(a_wr), .i_A_ADDR(a_addr), .i_A_WDATA(a_wdata),
    .o_A_DONE(a_done), .o_A_RDATA(a_rdata),
    .i_B_REQ(b_req), .i_B_WR(b_wr), .i_B_ADDR(b_addr), .i_B_WDATA(b_wdata),
    .o_B_DONE(b_done), .o_B_RDATA(b_rdata),
    .o_PSRAM_READ8(rd8), .o_PSRAM_WRITE8(wr8),
    .o_PSRAM_ADDRESS(p_addr), .o_PSRAM_WRITE_DATA(p_wdata),
    .i_PSRAM_BUSY(busy), .i_PSRAM_READ_DATA(rd_data)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // -------------------------------------------------------------------------
  // PSRAM controller model. Runs on the falling edge so that busy and the
  // read byte are stable at the DUT's rising edge. Busy rises one cycle after
  // the strobe and stays high for BUSY_LEN cycles. A strobe that arrives
  // while a command is pending or busy is high breaks the protocol.
  // -------------------------------------------------------------------------
  logic [7:0]    mem [logic [AW-1:0]];
  int            init_left = 0;
  int            busy_left = 0;
  int            rise_cnt = 0;
  bit            pend = 0;
  bit            cur_wr = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [7:0]    cur_data = '0;
  int            busy_fall_cyc = 0;

  function automatic logic [7:0] memRead(input logic [AW-1:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return addr[7:0] ^ 8'hA5;
  endfunction

  always @(negedge clk) begin
    bit was_busy;
    was_busy = busy;
    if (rd8 === 1'b1 || wr8 === 1'b1) begin
      checkOutput("strobe_spacing", {63'd0, (pend || busy_left > 0 || init_left > 0)}, 64'd0);
      pend     = 1;
      rise_cnt = 1;
      cur_wr   = (wr8 === 1'b1);
      cur_addr = p_addr;
      cur_data = p_wdata;
    end
    if (init_left > 0) begin
      init_left--;
    end else if (pend) begin
      if (rise_cnt > 0) begin
        rise_cnt--;
      end else begin
        pend      = 0;
        busy_left = BUSY_LEN;
        rd_data   = 8'hEE;
        if (cur_wr) mem[cur_addr] = cur_data;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0 && !cur_wr) rd_data = memRead(cur_addr);
    end
    busy = (init_left > 0) || (busy_left > 0);
    if (was_busy && !busy) busy_fall_cyc = cyc;
  end

  // -------------------------------------------------------------------------
  // Reference model. At each rising edge it looks at the inputs the DUT also
  // samples and predicts the outputs for the next cycle. The rules:
  //   - one transaction at a time;
  //   - grant only when the controller is idle;
  //   - no grant in the cycle that carries a DONE pulse;
  //   - a transaction finishes once busy has been seen high (after the strobe
  //     cycle) and then low.
  // -------------------------------------------------------------------------
  bit            model_on = 0;
  bit            in_flight = 0;
  bit            strobe_cycle = 0;
  bit            seen_high = 0;
  bit            quiet = 0;
  bit            txn_b = 0;
  bit            txn_wr = 0;
  logic          exp_rd8 = 0, exp_wr8 = 0, exp_da = 0, exp_db = 0;
  logic [7:0]    exp_ra = 0, exp_rb = 0, exp_wd = 0;
  logic [AW-1:0] exp_addr = '0;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
  bit            last_b = 1;
`endif

  always @(posedge clk) begin
    cyc++;
    if (rst_n === 1'b0) begin
      model_on  = 1;
      in_flight = 0;
      quiet     = 0;
      exp_rd8 = 0; exp_wr8 = 0; exp_da = 0; exp_db = 0;
      exp_ra = 0; exp_rb = 0; exp_wd = 0; exp_addr = '0;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
      last_b = 1;
`endif
    end else if (model_on) begin
      exp_rd8 = 0; exp_wr8 = 0; exp_da = 0; exp_db = 0;
      if (in_flight) begin
        if (strobe_cycle) begin
          strobe_cycle = 0;
        end else if (!seen_high) begin
          seen_high = busy;
        end else if (!busy) begin
          in_flight = 0;
          quiet     = 1;
          if (txn_b) exp_db = 1; else exp_da = 1;
          if (!txn_wr) begin
            if (txn_b) exp_rb = rd_data; else exp_ra = rd_data;
          end
        end
      end else if (quiet) begin
        quiet = 0;
      end else if (!busy && (a_req || b_req)) begin
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
        txn_b  = b_req && (!a_req || !last_b);
        last_b = txn_b;
`else
        txn_b = !a_req;
`endif
        txn_wr       = txn_b ? b_wr : a_wr;
        exp_addr     = txn_b ? b_addr : a_addr;
        exp_wd       = txn_b ? b_wdata : a_wdata;
        exp_rd8      = !txn_wr;
        exp_wr8      = txn_wr;
        in_flight    = 1;
        strobe_cycle = 1;
        seen_high    = 0;
      end
    end
  end

  // Compare the DUT against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("strobes_done", {60'd0, rd8, wr8, a_done, b_done},
                  {60'd0, exp_rd8, exp_wr8, exp_da, exp_db});
      checkOutput("psram_address", {42'd0, p_addr}, {42'd0, exp_addr});
      checkOutput("psram_wdata", {56'd0, p_wdata}, {56'd0, exp_wd});
      checkOutput("client_rdata", {48'd0, a_rdata, b_rdata}, {48'd0, exp_ra, exp_rb});
    end
  end

  // Event counters used by the directed scenarios.
  int            a_dones = 0, b_dones = 0, rd8_cnt = 0, wr8_cnt = 0;
  int            strobe_cyc = 0, done_cyc = 0;
  logic [AW-1:0] strobe_addr = '0;
  logic [7:0]    strobe_wdata = '0;
  bit            done_log [$];

  always @(negedge clk) begin
    if (a_done === 1'b1) begin a_dones++; done_log.push_back(1'b0); done_cyc = cyc; end
    if (b_done === 1'b1) begin b_dones++; done_log.push_back(1'b1); done_cyc = cyc; end
    if (rd8 === 1'b1) begin rd8_cnt++; strobe_cyc = cyc; strobe_addr = p_addr; end
    if (wr8 === 1'b1) begin
      wr8_cnt++; strobe_cyc = cyc; strobe_addr = p_addr; strobe_wdata = p_wdata;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit client_b, input bit req, input bit wr,
                               input logic [AW-1:0] addr, input logic [7:0] wdata);
    if (client_b) begin
      b_req = req; b_wr = wr; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_wr = wr; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic waitTotalDones(input string name, input int target, input int limit);
    int n = 0;
    while ((a_dones + b_dones) < target && n < limit) begin tick(); n++; end
    checkOutput(name, {63'd0, (a_dones + b_dones) >= target}, 64'd1);
  endtask

  task automatic waitStrobes(input string name, input int target, input int limit);
    int n = 0;
    while ((rd8_cnt + wr8_cnt) < target && n < limit) begin tick(); n++; end
    checkOutput(name, {63'd0, (rd8_cnt + wr8_cnt) >= target}, 64'd1);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_rd, base_wr, base_a, base_b, req_cyc, rel_cyc, n;
    bit exp_order [4];

    mem[22'h000123] = 8'h5A;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, '0, 8'h00);
    applyStimulus(1, 0, 0, '0, 8'h00);
    repeat (3) tick();
    checkOutput("reset_outputs", {14'd0, rd8, wr8, a_done, b_done, a_rdata, b_rdata, p_addr, p_wdata}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("[TB] single read from client A");
    base_rd = rd8_cnt; base_wr = wr8_cnt; base_a = a_dones; base_b = b_dones;
    applyStimulus(0, 1, 0, 22'h000123, 8'h00);
    req_cyc = cyc;
    waitTotalDones("s1_done_timeout", base_a + base_b + 1, 100);
    applyStimulus(0, 0, 0, 22'h000123, 8'h00);
    checkOutput("s1_read8_count", rd8_cnt - base_rd, 1);
    checkOutput("s1_write8_count", wr8_cnt - base_wr, 0);
    checkOutput("s1_address", {42'd0, strobe_addr}, 64'h000123);
    checkOutput("s1_strobe_latency", strobe_cyc - req_cyc, 1);
    checkOutput("s1_done_latency", done_cyc - busy_fall_cyc, 1);
    checkOutput("s1_a_rdata", {56'd0, a_rdata}, 64'h5A);
    checkOutput("s1_done_counts", {(a_dones - base_a), (b_dones - base_b)}, {32'd1, 32'd0});
    repeat (3) tick();

    $display("[TB] single write from client B");
    base_rd = rd8_cnt; base_wr = wr8_cnt; base_a = a_dones; base_b = b_dones;
    applyStimulus(1, 1, 1, 22'h3FFFFF, 8'hC3);
    waitTotalDones("s2_done_timeout", base_a + base_b + 1, 100);
    applyStimulus(1, 0, 1, 22'h3FFFFF, 8'hC3);
    checkOutput("s2_write8_count", wr8_cnt - base_wr, 1);
    checkOutput("s2_read8_count", rd8_cnt - base_rd, 0);
    checkOutput("s2_address", {42'd0, strobe_addr}, 64'h3FFFFF);
    checkOutput("s2_write_data", {56'd0, strobe_wdata}, 64'hC3);
    checkOutput("s2_rdata_unchanged", {48'd0, a_rdata, b_rdata}, 64'h5A00);
    checkOutput("s2_done_counts", {(a_dones - base_a), (b_dones - base_b)}, {32'd0, 32'd1});
    repeat (3) tick();

    $display("[TB] simultaneous requests, four transactions");
    done_log.delete();
    base_a = a_dones; base_b = b_dones;
    applyStimulus(0, 1, 0, 22'h000010, 8'h00);
    applyStimulus(1, 1, 0, 22'h000020, 8'h00);
    waitTotalDones("s3_done_timeout", base_a + base_b + 4, 200);
    applyStimulus(0, 0, 0, 22'h000010, 8'h00);
    applyStimulus(1, 0, 0, 22'h000020, 8'h00);
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    checkOutput("s3_rdata", {48'd0, a_rdata, b_rdata}, 64'hB585);
`else
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
    checkOutput("s3_rdata", {48'd0, a_rdata, b_rdata}, 64'hB500);
`endif
    checkOutput("s3_done_log_size", done_log.size(), 4);
    for (int i = 0; i < 4 && i < done_log.size(); i++) begin
      checkOutput($sformatf("s3_grant_order_%0d", i), {63'd0, done_log[i]}, {63'd0, exp_order[i]});
    end
    repeat (3) tick();

    $display("[TB] back-to-back reads from client A");
    base_rd = rd8_cnt; base_a = a_dones; base_b = b_dones;
    applyStimulus(0, 1, 0, 22'h000003, 8'h00);
    waitTotalDones("s4_done_timeout", base_a + base_b + 3, 200);
    applyStimulus(0, 0, 0, 22'h000003, 8'h00);
    checkOutput("s4_a_done_count", a_dones - base_a, 3);
    checkOutput("s4_read8_count", rd8_cnt - base_rd, 3);
    checkOutput("s4_a_rdata", {56'd0, a_rdata}, 64'hA6);
    repeat (3) tick();

    $display("[TB] reset while waiting for completion");
    base_rd = rd8_cnt; base_a = a_dones; base_b = b_dones;
    applyStimulus(0, 1, 0, 22'h000040, 8'h00);
    waitStrobes("s5_strobe_timeout", rd8_cnt + wr8_cnt + 1, 50);
    n = 0;
    while (n < 3) begin tick(); if (busy) n++; end
    rst_n = 1'b0;
    tick();
    checkOutput("s5_reset_outputs", {14'd0, rd8, wr8, a_done, b_done, a_rdata, b_rdata, p_addr, p_wdata}, 64'd0);
    rst_n = 1'b1;
    waitTotalDones("s5_done_timeout", base_a + base_b + 1, 100);
    applyStimulus(0, 0, 0, 22'h000040, 8'h00);
    checkOutput("s5_read8_count", rd8_cnt - base_rd, 2);
    checkOutput("s5_a_done_count", a_dones - base_a, 1);
    checkOutput("s5_a_rdata", {56'd0, a_rdata}, 64'hE5);
    repeat (3) tick();

    $display("[TB] controller init hold-off after reset");
    base_rd = rd8_cnt; base_a = a_dones; base_b = b_dones;
    rst_n = 1'b0;
    init_left = 2000;
    applyStimulus(0, 1, 0, 22'h000123, 8'h00);
    tick();
    rst_n = 1'b1;
    rel_cyc = cyc;
    waitStrobes("s6_strobe_timeout", rd8_cnt + wr8_cnt + 1, 2200);
    checkOutput("s6_strobe_after_busy_fall", strobe_cyc - busy_fall_cyc, 1);
    checkOutput("s6_holdoff_length", {63'd0, (strobe_cyc - rel_cyc) >= 2000}, 64'd1);
    waitTotalDones("s6_done_timeout", base_a + base_b + 1, 100);
    applyStimulus(0, 0, 0, 22'h000123, 8'h00);
    checkOutput("s6_read8_count", rd8_cnt - base_rd, 1);
    checkOutput("s6_a_rdata", {56'd0, a_rdata}, 64'h5A);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
